// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// uart_tx_if : request/line bundle between a byte source and the UART TX.
// Rev 1.0
// ============================================================================
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  uart_tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output uart_tx,
    output tx_busy,
    output tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : 8N1 UART transmitter (start, 8 data bits LSB-first, stop).
// Rev 1.0
// ============================================================================
module uart_tx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input wire       clk,
  input wire       rst,
  uart_tx_if.slave bus
);

  localparam int          CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] C_BIT_LAST   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e      state_q,     state_d;
  logic [15:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q,     shift_d;
  logic        line_q,      line_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        w_bit_end;

  assign w_bit_end = (clk_count_q == C_BIT_LAST);

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    line_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        line_d      = 1'b1;
        clk_count_d = 16'd0;
        if (bus.tx_start) begin
          shift_d = bus.tx_data;
          state_d = S_START;
        end
      end
      S_START: begin
        line_d = 1'b0;
        if (w_bit_end) begin
          clk_count_d = 16'd0;
          bit_index_d = 3'd0;
          state_d     = S_DATA;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      S_DATA: begin
        line_d = shift_q[bit_index_q];
        if (w_bit_end) begin
          clk_count_d = 16'd0;
          if (bit_index_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      S_STOP: begin
        line_d = 1'b1;
        if (w_bit_end) begin
          clk_count_d = 16'd0;
          state_d     = S_IDLE;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
    endcase

    // Flags are registered from next-state so they line up with state_q.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (clk_count_d == C_BIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_count_q <= 16'd0;
      bit_index_q <= 3'd0;
      shift_q     <= 8'd0;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.uart_tx = line_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : randomized self-checking bench for uart_tx.
// Rev 1.0
// ============================================================================
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam int CPBD  = 50000000 / 115200;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_tx_if bus_a ();
  uart_tx_if bus_d ();

  uart_tx #(.CLOCK_FREQ(16), .BAUD_RATE(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  uart_tx u_def (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  // Expected line level t cycles after the acceptance edge.
  function automatic logic exp_line(input logic [7:0] d, input int t);
    int b;
    if (t < 1) return 1'b1;
    b = (t - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit noise, input bit hold,
                           input logic [7:0] next_d, input logic [7:0] noise_d,
                           input string tag);
    logic eb, ed;
    @(posedge clk);
    for (int t = 0; t <= FRAME; t++) begin
      @(negedge clk);
      eb = (t < FRAME);
      ed = (t == FRAME - 1);
      total++;
      if (bus_a.uart_tx !== exp_line(d, t)) begin
        bad++;
        $display("FAIL %s line t=%0d data=%h got=%b exp=%b", tag, t, d, bus_a.uart_tx, exp_line(d, t));
      end
      total++;
      if (bus_a.tx_busy !== eb) begin
        bad++;
        $display("FAIL %s busy t=%0d got=%b exp=%b", tag, t, bus_a.tx_busy, eb);
      end
      total++;
      if (bus_a.tx_done !== ed) begin
        bad++;
        $display("FAIL %s done t=%0d got=%b exp=%b", tag, t, bus_a.tx_done, ed);
      end
      if (noise && t < FRAME - 1) begin
        bus_a.tx_start = 1'($urandom_range(0, 1));
        bus_a.tx_data  = noise_d ^ 8'($urandom_range(0, 1));
      end else begin
        bus_a.tx_start = hold;
        bus_a.tx_data  = (t >= FRAME - 1) ? next_d : 8'($urandom);
      end
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (bus_a.uart_tx !== 1'b1 || bus_a.tx_busy !== 1'b0 || bus_a.tx_done !== 1'b0) begin
        bad++;
        $display("FAIL %s idle i=%0d got line/busy/done=%b%b%b exp=100", tag, i,
                 bus_a.uart_tx, bus_a.tx_busy, bus_a.tx_done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'hC3;
    bus_d.tx_start = 1'b1;
    bus_d.tx_data  = 8'hC3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus_a.uart_tx, bus_a.tx_busy, bus_a.tx_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_a got=%b exp=100", {bus_a.uart_tx, bus_a.tx_busy, bus_a.tx_done});
    end
    total++;
    if ({bus_d.uart_tx, bus_d.tx_busy, bus_d.tx_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_d got=%b exp=100", {bus_d.uart_tx, bus_d.tx_busy, bus_d.tx_done});
    end
    bus_a.tx_start = 1'b0;
    bus_d.tx_start = 1'b0;
    rst = 1'b0;
    check_idle(4, "reset_release");
  endtask

  task automatic test_a5();
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'hA5;
    run_frame(8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, "a5");
    check_idle(CPB, "a5_after");
  endtask

  task automatic test_back_to_back();
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'h00;
    run_frame(8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, "b2b_00");
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, "b2b_ff");
    check_idle(CPB, "b2b_after");
  endtask

  task automatic test_ignore_busy();
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'h81;
    run_frame(8'h81, 1'b1, 1'b0, 8'h3C, 8'h3C, "ignore_81");
    check_idle(2 * CPB, "ignore_after");
  endtask

  task automatic test_reset_mid();
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'($urandom);
    @(posedge clk);
    for (int t = 0; t < 4 * CPB + 5; t++) begin
      @(negedge clk);
      bus_a.tx_start = 1'b0;
    end
    total++;
    if (bus_a.tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid pre busy got=%b exp=1", bus_a.tx_busy);
    end
    rst = 1'b1;
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'h5A;
    check_idle(2, "rst_mid_hold");
    rst = 1'b0;
    bus_a.tx_start = 1'b0;
    check_idle(3 * CPB, "rst_mid_quiet");
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = 8'h5A;
    run_frame(8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, "rst_mid_5a");
  endtask

  task automatic test_random();
    logic [7:0] d, nd;
    bit hold, noise;
    d = 8'($urandom);
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = d;
    for (int i = 0; i < 20; i++) begin
      hold  = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      nd    = 8'($urandom);
      run_frame(d, noise, hold, nd, 8'($urandom), "random");
      if (!hold) begin
        check_idle(int'($urandom_range(1, 5)), "random_gap");
        bus_a.tx_start = 1'b1;
        bus_a.tx_data  = nd;
      end
      d = nd;
    end
    @(posedge clk);
    @(negedge clk);
    bus_a.tx_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    bus_a.tx_start = 1'b0;
    check_idle(1000, "idle_1000");
  endtask

  task automatic test_loopback();
    logic [7:0] rx;
    logic       stop_bit;
    int         n;
    bus_d.tx_start = 1'b1;
    bus_d.tx_data  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus_d.tx_start = 1'b0;
    bus_d.tx_data  = 8'hFF;
    n = 0;
    while (bus_d.uart_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL loopback start bit not seen got=%b exp=0", bus_d.uart_tx);
    end
    repeat (CPBD / 2) @(negedge clk);
    total++;
    if (bus_d.uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL loopback mid start got=%b exp=0", bus_d.uart_tx);
    end
    for (int k = 0; k < 8; k++) begin
      repeat (CPBD) @(negedge clk);
      rx[k] = bus_d.uart_tx;
    end
    repeat (CPBD) @(negedge clk);
    stop_bit = bus_d.uart_tx;
    total++;
    if (rx !== 8'h3C) begin
      bad++;
      $display("FAIL loopback byte got=%h exp=3c", rx);
    end
    total++;
    if (stop_bit !== 1'b1) begin
      bad++;
      $display("FAIL loopback stop got=%b exp=1", stop_bit);
    end
    n = 0;
    while (bus_d.tx_busy !== 1'b0 && n < CPBD) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus_d.tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL loopback busy end got=%b exp=0", bus_d.tx_busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_a.tx_start = 1'b0;
    bus_a.tx_data  = 8'h00;
    bus_d.tx_start = 1'b0;
    bus_d.tx_data  = 8'h00;
    test_reset();
    test_a5();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_idle();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
